muldiv_sched: RTL
=================

Name: muldiv_sched

Overview:
- Two-requester scheduler in front of the shared muldiv unit; the requesters are the core execute stage (port 0) and a coprocessor/debug path (port 1).
- Arbitrates round-robin, registers the winning operands, and holds them stable on the downstream handshake until the unit completes.
- A multiply finishes in the same cycle. A divide takes several cycles.
- Routes the result back to the owner with a valid/ready response, and supports per-requester flush of an in-flight op.

Parameters:
- W, 32, operand/result width.
- TAGW, 4, width of the requester tag that is echoed with the response.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset; one clock, synchronous, active-low.
- req_valid  in  2  per-requester request valid.
- req_ready  out  2  per-requester accept; one-hot or zero.
- req_op  in  2x3  per-requester func3; bit2=1 means divide/rem.
- req_op1  in  2xW  per-requester operand 1.
- req_op2  in  2xW  per-requester operand 2.
- req_tag  in  2xTAGW  per-requester tag.
- flush  in  2  per-requester kill of that requester's outstanding op.
- rsp_valid  out  2  per-requester response valid.
- rsp_ready  in  2  per-requester response accept.
- rsp_data  out  W  result; meaningful only where rsp_valid is set.
- rsp_tag  out  TAGW  tag of the op being responded.
- md_valid  out  1  downstream op valid.
- md_ready  in  1  downstream done; result on md_out in the same cycle.
- md_op  out  3  downstream func3.
- md_op1  out  W  downstream operand 1.
- md_op2  out  W  downstream operand 2.
- md_out  in  W  downstream result.
- busy  out  1  state != IDLE.

Behaviour:
- Reset values (on rstn=0 at a clk edge): state=IDLE, rr_ptr=0, grant=0, all outputs 0, operand/result/tag registers 0.
- Reset mid-op: state returns to IDLE and nothing is responded. The downstream divider shares rstn, so it resets too.

State IDLE:
- Candidate requester: if req_valid[rr_ptr], pick rr_ptr; else if req_valid[~rr_ptr], pick ~rr_ptr; else no candidate.
- Accept the candidate g only if flush[g]=0. A flushed candidate is not accepted and the other requester is not considered in that cycle.
- On accept: req_ready[g]=1 (combinational, this cycle), latch op/op1/op2/tag and grant=g, go ISSUE.

State ISSUE:
- md_valid=1; md_op/md_op1/md_op2 come from the registers and are held stable until md_ready.
- md_ready=1 and flush[grant]=0: capture md_out into the result register, go RESP.
- md_ready=1 and flush[grant]=1: discard the result, rr_ptr=~grant, go IDLE.
- md_ready=0 and flush[grant]=1: go DRAIN. The divider cannot abort, so the op must still complete.

State DRAIN:
- md_valid=1 with the same held operands.
- On md_ready: discard the result, rr_ptr=~grant, go IDLE. flush is ignored in this state.

State RESP:
- rsp_valid[grant]=1; rsp_data and rsp_tag come from the registers and are held until the handshake.
- rsp_ready[grant]=1 or flush[grant]=1: rsp_valid drops next cycle, rr_ptr=~grant, go IDLE.

Timing and ordering:
- Latency: accept at cycle N; md_valid at N+1. A multiply gets md_ready at N+1, so rsp_valid rises at N+2. A divide takes N+1+D+1, where D is the divider's cycle count.
- Minimum spacing between accepts is 3 cycles. At most one op is in flight in total.
- req_ready is never asserted outside IDLE.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1.
- md_valid is never asserted in IDLE or RESP. The downstream unit therefore sees valid only with stable operands.

Test Plan:
1. MUL at reset: req0 only, op=000, op1=7, op2=-3 (0xFFFFFFFD). Expect req_ready=01 at N, md_valid at N+1, rsp_valid=01 at N+2 with rsp_data=0xFFFFFFEB and tag echoed.
2. Contention: both requesters valid every cycle, req0 MULHU 0xFFFFFFFF*0xFFFFFFFF, req1 DIV 100/7. Expect grant order 0,1,0,1. req0 result 0xFFFFFFFE, req1 result 14 (14 again on the repeat).
3. Divide hold: req1 DIVU 0x80000000/3 with a multi-cycle md_ready. Across every cycle until md_ready: md_op1/md_op2 unchanged, req_ready=00, busy=1. Result 0x2AAAAAAA.
4. Flush mid-divide: flush[0] pulsed two cycles after md_valid rises on a req0 DIV. Expect DRAIN: md_valid held until md_ready, rsp_valid never set, IDLE next, then req1 is granted first.
5. Response backpressure: rsp_ready[0]=0 for 5 cycles after a MUL result. rsp_valid/rsp_data held for the 5 cycles; a pending req1 is not accepted until 1 cycle after the rsp handshake.
6. Reset mid-op: drop rstn for one edge during ISSUE. Next cycle: all outputs 0, state IDLE. A new req0 MUL 2*3 then returns 6.

Source files
------------

// File: rtl/muldiv_sched.sv
// Two-requester round-robin scheduler in front of a shared multiply/divide unit.
// Port 0 is the core execute stage, port 1 the coprocessor/debug path. A single
// operation is in flight at a time: it is registered on accept, held stable on
// the downstream handshake until the unit reports done, and the result is
// returned to its owner with a valid/ready response. Each requester can kill
// its own outstanding operation with flush; a divide that has already been
// issued cannot be aborted downstream, so it is drained and its result dropped.
module muldiv_sched #(
  parameter int W    = 32,
  parameter int TAGW = 4
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [5:0]          req_op,
  input  logic [2*W-1:0]      req_op1,
  input  logic [2*W-1:0]      req_op2,
  input  logic [2*TAGW-1:0]   req_tag,
  input  logic [1:0]          flush,
  output logic [1:0]          rsp_valid,
  input  logic [1:0]          rsp_ready,
  output logic [W-1:0]        rsp_data,
  output logic [TAGW-1:0]     rsp_tag,
  output logic                md_valid,
  input  logic                md_ready,
  output logic [2:0]          md_op,
  output logic [W-1:0]        md_op1,
  output logic [W-1:0]        md_op2,
  input  logic [W-1:0]        md_out,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              rr_ptr_q, rr_ptr_d;
  logic              grant_q, grant_d;
  logic [2:0]        op_q, op_d;
  logic [W-1:0]      op1_q, op1_d;
  logic [W-1:0]      op2_q, op2_d;
  logic [TAGW-1:0]   tag_q, tag_d;
  logic [W-1:0]      result_q, result_d;

  logic              cand_valid;
  logic              cand_sel;
  logic [2:0]        cand_op;
  logic [W-1:0]      cand_op1;
  logic [W-1:0]      cand_op2;
  logic [TAGW-1:0]   cand_tag;

  // Round-robin candidate: the pointed-to requester wins if valid, otherwise the other one.
  always_comb begin
    cand_valid = 1'b0;
    cand_sel   = rr_ptr_q;
    if (req_valid[rr_ptr_q]) begin
      cand_valid = 1'b1;
      cand_sel   = rr_ptr_q;
    end else if (req_valid[~rr_ptr_q]) begin
      cand_valid = 1'b1;
      cand_sel   = ~rr_ptr_q;
    end
  end

  // Select the candidate's operation fields from the flattened per-requester buses.
  always_comb begin
    if (cand_sel) begin
      cand_op  = req_op[5:3];
      cand_op1 = req_op1[2*W-1:W];
      cand_op2 = req_op2[2*W-1:W];
      cand_tag = req_tag[2*TAGW-1:TAGW];
    end else begin
      cand_op  = req_op[2:0];
      cand_op1 = req_op1[W-1:0];
      cand_op2 = req_op2[W-1:0];
      cand_tag = req_tag[TAGW-1:0];
    end
  end

  // Next-state and handshake logic; a flushed candidate blocks the other requester for that cycle.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_q;
    op_d      = op_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    tag_d     = tag_q;
    result_d  = result_q;
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    md_valid  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cand_valid && !flush[cand_sel]) begin
          req_ready[cand_sel] = 1'b1;
          grant_d             = cand_sel;
          op_d                = cand_op;
          op1_d               = cand_op1;
          op2_d               = cand_op2;
          tag_d               = cand_tag;
          state_d             = ISSUE;
        end
      end

      ISSUE: begin
        md_valid = 1'b1;
        if (md_ready) begin
          if (flush[grant_q]) begin
            rr_ptr_d = ~grant_q;
            state_d  = IDLE;
          end else begin
            result_d = md_out;
            state_d  = RESP;
          end
        end else if (flush[grant_q]) begin
          state_d = DRAIN;
        end
      end

      DRAIN: begin
        md_valid = 1'b1;
        if (md_ready) begin
          rr_ptr_d = ~grant_q;
          state_d  = IDLE;
        end
      end

      RESP: begin
        rsp_valid[grant_q] = 1'b1;
        if (rsp_ready[grant_q] || flush[grant_q]) begin
          rr_ptr_d = ~grant_q;
          state_d  = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, arbitration pointer and held operand/result registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= IDLE;
      rr_ptr_q <= 1'b0;
      grant_q  <= 1'b0;
      op_q     <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      tag_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      op_q     <= op_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      tag_q    <= tag_d;
      result_q <= result_d;
    end
  end

  assign md_op    = op_q;
  assign md_op1   = op1_q;
  assign md_op2   = op2_q;
  assign rsp_data = result_q;
  assign rsp_tag  = tag_q;
  assign busy     = (state_q != IDLE);

endmodule
